// File: rtl/dco_lock_ctrl_if.sv
// Control/status bundle between the user side and the DCO lock controller.
// master drives the request (ena, start, target); slave reports progress and result.
interface dco_lock_ctrl_if;
  logic       ena;
  logic       start;
  logic [7:0] target;
  logic       busy;
  logic       locked;
  logic       fail;
  logic [7:0] meas;

  modport master (output ena, start, target, input busy, locked, fail, meas);
  modport slave  (input ena, start, target, output busy, locked, fail, meas);
endinterface

// File: rtl/dco_lock_ctrl.sv
// SAR lock controller for the one-hot DCO: searches 3 level bits, then verifies and locks or fails.
// Define DCO_TRACK_EN to keep re-measuring while LOCKED and relock after two misses.
module dco_lock_ctrl #(
  parameter int SETTLE_CYC = 16,
  parameter int TIMEOUT    = 64,
  parameter int TOL        = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  dco_lock_ctrl_if.slave        ctrl,
  input  logic                  dco_in,
  output logic [7:0]            dco_code
);

  typedef enum logic [2:0] {IDLE, SETTLE, MEAS, DECIDE, LOCKED, FAIL} state_t;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TO_LAST     = 16'(TIMEOUT - 1);

  state_t      state, state_n;
  logic        dco_q, dco_edge;
  logic [2:0]  lvl, lvl_n, acc, acc_n, kept_acc;
  logic [1:0]  idx, idx_n;
  logic        verify, verify_n;
  logic [15:0] settle_cnt, settle_n, to_cnt, to_n;
  logic [7:0]  cnt, cnt_n, meas_q, meas_n;
  logic        armed, armed_n;
  logic        locked_q, locked_n, fail_q, fail_n;
  logic        miss, miss_n;
  logic        restart;
  logic        eng_armed, eng_done, eng_timeout;
  logic [7:0]  eng_cnt;
  logic [15:0] eng_to;
  logic signed [8:0] search_diff;

  function automatic logic in_tol(input logic [7:0] m, input logic [7:0] t);
    logic signed [8:0] d;
    logic [8:0]        mag;
    d   = $signed({1'b0, m}) - $signed({1'b0, t});
    mag = d[8] ? 9'(-d) : 9'(d);
    return mag <= 9'(TOL);
  endfunction

  assign dco_edge    = dco_in ^ dco_q;
  assign search_diff = $signed({1'b0, meas_q}) - $signed({1'b0, ctrl.target});

  assign dco_code    = 8'd1 << lvl;
  assign ctrl.busy   = (state == SETTLE) || (state == MEAS) || (state == DECIDE);
  assign ctrl.locked = locked_q;
  assign ctrl.fail   = fail_q;
  assign ctrl.meas   = meas_q;

  // Half-period measurement step: the first edge arms with count 1, the next edge completes.
  always_comb begin
    eng_armed   = armed;
    eng_cnt     = cnt;
    eng_to      = to_cnt;
    eng_done    = 1'b0;
    eng_timeout = 1'b0;
    if (dco_edge) begin
      eng_to = '0;
      if (armed) begin
        eng_done  = 1'b1;
        eng_armed = 1'b0;
        eng_cnt   = '0;
      end else begin
        eng_armed = 1'b1;
        eng_cnt   = 8'd1;
      end
    end else begin
      eng_timeout = (to_cnt == TO_LAST);
      eng_to      = to_cnt + 16'd1;
      if (armed && cnt != 8'hFF) eng_cnt = cnt + 8'd1;
    end
  end

  always_comb begin
    state_n  = state;
    lvl_n    = lvl;
    acc_n    = acc;
    idx_n    = idx;
    verify_n = verify;
    settle_n = settle_cnt;
    to_n     = to_cnt;
    cnt_n    = cnt;
    armed_n  = armed;
    meas_n   = meas_q;
    locked_n = locked_q;
    fail_n   = fail_q;
    miss_n   = miss;
    restart  = 1'b0;
    kept_acc = acc;
    if (!ctrl.ena) begin
      state_n  = IDLE;
      locked_n = 1'b0;
      fail_n   = 1'b0;
    end else begin
      case (state)
        IDLE, FAIL: restart = ctrl.start;
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state_n = MEAS;
            armed_n = 1'b0;
            cnt_n   = '0;
            to_n    = '0;
          end else begin
            settle_n = settle_cnt + 16'd1;
          end
        end
        MEAS: begin
          armed_n = eng_armed;
          cnt_n   = eng_cnt;
          to_n    = eng_to;
          if (eng_timeout) begin
            state_n = FAIL;
            fail_n  = 1'b1;
          end else if (eng_done) begin
            meas_n  = cnt;
            state_n = DECIDE;
          end
        end
        DECIDE: begin
          if (!verify) begin
            // lvl holds acc with the trial bit set, so keeping the bit means taking lvl
            kept_acc = (search_diff > 9'sd0) ? acc : lvl;
            acc_n    = kept_acc;
            settle_n = '0;
            state_n  = SETTLE;
            if (idx != 2'd0) begin
              idx_n = idx - 2'd1;
              lvl_n = kept_acc | (3'b001 << (idx - 2'd1));
            end else begin
              lvl_n    = kept_acc;
              verify_n = 1'b1;
            end
          end else if (in_tol(meas_q, ctrl.target)) begin
            state_n  = LOCKED;
            locked_n = 1'b1;
            armed_n  = 1'b0;
            cnt_n    = '0;
            to_n     = '0;
            miss_n   = 1'b0;
          end else begin
            state_n = FAIL;
            fail_n  = 1'b1;
          end
        end
        LOCKED: begin
          if (ctrl.start) restart = 1'b1;
`ifdef DCO_TRACK_EN
          else begin
            armed_n = eng_armed;
            cnt_n   = eng_cnt;
            to_n    = eng_to;
            if (eng_timeout) begin
              state_n  = FAIL;
              locked_n = 1'b0;
              fail_n   = 1'b1;
            end else if (eng_done) begin
              meas_n = cnt;
              if (in_tol(cnt, ctrl.target)) miss_n = 1'b0;
              else if (miss)                restart = 1'b1;
              else                          miss_n = 1'b1;
            end
          end
`endif
        end
        default: state_n = IDLE;
      endcase
      if (restart) begin
        state_n  = SETTLE;
        lvl_n    = 3'd4;
        acc_n    = '0;
        idx_n    = 2'd2;
        verify_n = 1'b0;
        settle_n = '0;
        locked_n = 1'b0;
        fail_n   = 1'b0;
        miss_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dco_q      <= 1'b0;
      lvl        <= '0;
      acc        <= '0;
      idx        <= '0;
      verify     <= 1'b0;
      settle_cnt <= '0;
      to_cnt     <= '0;
      cnt        <= '0;
      armed      <= 1'b0;
      meas_q     <= '0;
      locked_q   <= 1'b0;
      fail_q     <= 1'b0;
      miss       <= 1'b0;
    end else begin
      state      <= state_n;
      dco_q      <= dco_in;
      lvl        <= lvl_n;
      acc        <= acc_n;
      idx        <= idx_n;
      verify     <= verify_n;
      settle_cnt <= settle_n;
      to_cnt     <= to_n;
      cnt        <= cnt_n;
      armed      <= armed_n;
      meas_q     <= meas_n;
      locked_q   <= locked_n;
      fail_q     <= fail_n;
      miss       <= miss_n;
    end
  end

endmodule

// File: tb/tb_dco_lock_ctrl.sv
// Directed bench for dco_lock_ctrl with a behavioural DCO whose half-period is level+4 clocks.
module tb_dco_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dco_in;
  logic [7:0] dco_code;
  logic       dco_model = 1'b0;
  logic       force_low = 1'b0;
  int         hp_cnt = 0;
  int         hp = 4;
  int         total = 0;
  int         bad = 0;

  dco_lock_ctrl_if bus ();

  dco_lock_ctrl #(.SETTLE_CYC(16), .TIMEOUT(64), .TOL(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl     (bus),
    .dco_in   (dco_in),
    .dco_code (dco_code)
  );

  always #5 clk = ~clk;

  function automatic int codeLevel(input logic [7:0] c);
    int lv;
    lv = 0;
    for (int i = 0; i < 8; i++) if (c[i]) lv = i;
    return lv;
  endfunction

  // The DCO picks up a new level only at its own toggle, like the real period latch.
  always @(posedge clk) begin
    if (hp_cnt >= hp - 1) begin
      dco_model <= ~dco_model;
      hp_cnt    <= 0;
      hp        <= codeLevel(dco_code) + 4;
    end else begin
      hp_cnt <= hp_cnt + 1;
    end
  end

  assign dco_in = force_low ? 1'b0 : dco_model;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] tgt);
    @(negedge clk);
    bus.target = tgt;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic waitNotBusy(input int budget, input string tag);
    int n;
    n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("%s_finish", tag), 32'(bus.busy), 32'd0);
  endtask

  task automatic waitCode(input logic [7:0] code, input int budget, input string tag);
    int n;
    n = 0;
    while (dco_code !== code && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("%s_reach", tag), 32'(dco_code), 32'(code));
  endtask

  task automatic checkResult(input string tag, input logic [7:0] code, input logic [7:0] m,
                             input logic lk, input logic fl);
    checkOutput($sformatf("%s_code", tag),   32'(dco_code),   32'(code));
    checkOutput($sformatf("%s_meas", tag),   32'(bus.meas),   32'(m));
    checkOutput($sformatf("%s_locked", tag), 32'(bus.locked), 32'(lk));
    checkOutput($sformatf("%s_fail", tag),   32'(bus.fail),   32'(fl));
    checkOutput($sformatf("%s_busy", tag),   32'(bus.busy),   32'd0);
  endtask

  initial begin
    bus.ena    = 1'b1;
    bus.start  = 1'b0;
    bus.target = 8'd0;
    rst_n      = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checkResult("reset", 8'h01, 8'd0, 1'b0, 1'b0);

    // trials L=4 (8>7 drop), L=2 (keep), L=3 (keep) -> level 3
    applyStimulus(8'd7);
    checkOutput("t7_busy_on", 32'(bus.busy), 32'd1);
    checkOutput("t7_first_trial", 32'(dco_code), 32'h10);
    waitNotBusy(2000, "t7");
    checkResult("t7", 8'h08, 8'd7, 1'b1, 1'b0);

    applyStimulus(8'd11);
    waitNotBusy(2000, "t11");
    checkResult("t11", 8'h80, 8'd11, 1'b1, 1'b0);

    applyStimulus(8'd4);
    waitNotBusy(2000, "t4");
    checkResult("t4", 8'h01, 8'd4, 1'b1, 1'b0);

    @(negedge clk);
    bus.ena = 1'b0;
    @(negedge clk);
    checkOutput("ena_low_locked", 32'(bus.locked), 32'd0);
    checkOutput("ena_low_code", 32'(dco_code), 32'h01);
    bus.ena = 1'b1;

    applyStimulus(8'd2);
    waitNotBusy(2000, "t2");
    checkResult("t2", 8'h01, 8'd4, 1'b0, 1'b1);

    applyStimulus(8'd20);
    waitNotBusy(2000, "t20");
    checkResult("t20", 8'h80, 8'd11, 1'b0, 1'b1);

    // stuck DCO: MEAS is entered 16 clocks after start, fail 64 clocks later
    force_low = 1'b1;
    repeat (20) @(negedge clk);
    applyStimulus(8'd7);
    repeat (79) @(negedge clk);
    checkOutput("to_early_fail", 32'(bus.fail), 32'd0);
    checkOutput("to_early_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput("to_fail", 32'(bus.fail), 32'd1);
    checkOutput("to_busy", 32'(bus.busy), 32'd0);
    checkOutput("to_locked", 32'(bus.locked), 32'd0);
    force_low = 1'b0;
    repeat (30) @(negedge clk);

    applyStimulus(8'd7);
    waitCode(8'h04, 500, "sb");
    applyStimulus(8'd7);
    checkOutput("sb_code_kept", 32'(dco_code), 32'h04);
    checkOutput("sb_busy", 32'(bus.busy), 32'd1);
    waitNotBusy(2000, "sb");
    checkResult("sb", 8'h08, 8'd7, 1'b1, 1'b0);

    applyStimulus(8'd9);
    repeat (5) @(negedge clk);
    bus.ena = 1'b0;
    @(negedge clk);
    checkOutput("ena_abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("ena_abort_code", 32'(dco_code), 32'h10);
    checkOutput("ena_abort_locked", 32'(bus.locked), 32'd0);
    repeat (3) @(negedge clk);
    bus.ena = 1'b1;
    @(negedge clk);
    bus.ena   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.ena   = 1'b1;
    checkOutput("ena_wins_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("ena_wins_busy2", 32'(bus.busy), 32'd0);

    applyStimulus(8'd9);
    repeat (20) @(negedge clk);
    checkOutput("rst_pre_code", 32'(dco_code), 32'h10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_code", 32'(dco_code), 32'h01);
    checkOutput("rst_mid_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_mid_locked", 32'(bus.locked), 32'd0);
    checkOutput("rst_mid_fail", 32'(bus.fail), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd9);
    waitNotBusy(2000, "t9");
    checkResult("t9", 8'h20, 8'd9, 1'b1, 1'b0);

`ifdef DCO_TRACK_EN
    applyStimulus(8'd6);
    waitNotBusy(2000, "tr6");
    checkResult("tr6", 8'h04, 8'd6, 1'b1, 1'b0);
    begin
      int n;
      n = 0;
      @(negedge clk);
      bus.target = 8'd10;
      while (bus.locked && n < 300) begin
        @(negedge clk);
        n++;
      end
      checkOutput("tr_drop", 32'(bus.locked), 32'd0);
      checkOutput("tr_relock_busy", 32'(bus.busy), 32'd1);
    end
    waitNotBusy(2000, "tr10");
    checkResult("tr10", 8'h40, 8'd10, 1'b1, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
